// File: rtl/alu_control_mdu_if.sv
// ALU control / multiply-divide bus between control unit, register file and ALU.
// Carries decode inputs, operands, and the ALU code, stall and HI/LO results.
// The master drives instruction fields and operands; the slave returns results.
interface alu_control_mdu_if #(
  parameter int DATA_WIDTH = 32
);
  logic [5:0]            ALUOp;
  logic [5:0]            ALUFunction;
  logic                  Enable;
  logic [DATA_WIDTH-1:0] ReadData1;
  logic [DATA_WIDTH-1:0] ReadData2;
  logic [3:0]            ALUOperation;
  logic                  Stall;
  logic                  Busy;
  logic [DATA_WIDTH-1:0] HI;
  logic [DATA_WIDTH-1:0] LO;

  modport master (
    output ALUOp, ALUFunction, Enable, ReadData1, ReadData2,
    input  ALUOperation, Stall, Busy, HI, LO
  );

  modport slave (
    input  ALUOp, ALUFunction, Enable, ReadData1, ReadData2,
    output ALUOperation, Stall, Busy, HI, LO
  );
endinterface

// File: rtl/alu_control_mdu.sv
// ALU control decode plus iterative unsigned MULTU/DIVU sequencer with HI/LO.
// Decode is zero latency; MULTU/DIVU results land in HI/LO DATA_WIDTH+1 cycles after issue.
// Stall holds the PC/pipeline from the issue cycle through the last iteration; low in DONE.
module alu_control_mdu #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  alu_control_mdu_if.slave    bus
);

  localparam int W         = DATA_WIDTH;
  localparam int CNT_WIDTH = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state;
  state_t               state_nxt;
  logic [CNT_WIDTH-1:0] cnt;
  logic [2*W-1:0]       acc;
  logic [2*W-1:0]       acc_next;
  logic [W-1:0]         opnd;
  logic                 is_div;
  logic [W-1:0]         hi;
  logic [W-1:0]         lo;
  logic [3:0]           code;
  logic                 is_mdu;
  logic                 issue;
  logic                 last_iter;

  // Division step helpers: partial remainder with next dividend bit shifted in.
  logic [W:0]           partial;
  logic                 sub_ok;
  logic [W-1:0]         rem_sub;
  logic [W:0]           sum_mul;

  assign is_mdu    = (bus.ALUOp == 6'h00) &&
                     ((bus.ALUFunction == 6'h19) || (bus.ALUFunction == 6'h1B));
  assign last_iter = (cnt == CNT_WIDTH'(1));

  // Instruction decode into the ALU operation code; first matching row wins.
  always_comb begin
    code = 4'b1001;
    casez ({bus.ALUOp, bus.ALUFunction})
      12'b000000_100100: code = 4'b0000;  // AND
      12'b000000_100101: code = 4'b0001;  // OR
      12'b000000_100111: code = 4'b0010;  // NOR
      12'b000000_100000: code = 4'b0011;  // ADD
      12'b000000_100010: code = 4'b0100;  // SUB
      12'b000000_000010: code = 4'b0110;  // SRL
      12'b000000_000000: code = 4'b0111;  // SLL
      12'b001000_??????: code = 4'b0011;  // ADDI
      12'b001101_??????: code = 4'b0001;  // ORI
      12'b001111_??????: code = 4'b0101;  // LUI
      12'b100011_??????: code = 4'b1000;  // LW
      12'b101011_??????: code = 4'b1001;  // SW
      12'b000100_??????: code = 4'b0100;  // BEQ
      12'b000000_010000: code = 4'b1010;  // MFHI
      12'b000000_010010: code = 4'b1011;  // MFLO
      12'b000000_011001: code = 4'b1111;  // MULTU
      12'b000000_011011: code = 4'b1111;  // DIVU
      default:           code = 4'b1001;
    endcase
  end

  // One radix-2 iteration: shift-add for multiply, restoring subtract for divide.
  always_comb begin
    sum_mul  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : {(W+1){1'b0}});
    partial  = acc[2*W-1:W-1];
    sub_ok   = (partial >= {1'b0, opnd});
    rem_sub  = W'(partial - {1'b0, opnd});
    acc_next = {sum_mul, acc[W-1:1]};
    if (is_div) begin
      if (sub_ok) acc_next = {rem_sub, acc[W-2:0], 1'b1};
      else        acc_next = {acc[2*W-2:0], 1'b0};
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake outputs; Stall is forced low while reset is held.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        issue = bus.Enable && is_mdu;
        if (issue) state_nxt = BUSY;
      end
      BUSY:    if (last_iter) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    bus.Stall        = reset && (issue || (state == BUSY));
    bus.Busy         = (state != IDLE);
    bus.ALUOperation = code;
    bus.HI           = hi;
    bus.LO           = lo;
  end

  // Operand capture on issue, iteration in BUSY, HI/LO written on the last iteration.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      is_div <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else if (issue) begin
      is_div <= (bus.ALUFunction == 6'h1B);
      cnt    <= CNT_WIDTH'(W);
      if (bus.ALUFunction == 6'h1B) begin
        acc  <= {{W{1'b0}}, bus.ReadData1};
        opnd <= bus.ReadData2;
      end else begin
        acc  <= {{W{1'b0}}, bus.ReadData2};
        opnd <= bus.ReadData1;
      end
    end else if (state == BUSY) begin
      acc <= acc_next;
      cnt <= cnt - CNT_WIDTH'(1);
      if (last_iter) begin
        hi <= acc_next[2*W-1:W];
        lo <= acc_next[W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_alu_control_mdu.sv
// Randomized self-checking bench for alu_control_mdu at DATA_WIDTH 8 and 32.
// Reference model: table lookup decode and plain *, /, % arithmetic.
// Both instances share decode/operand inputs; each has its own Enable.
module tb_alu_control_mdu;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  alu_op;
  logic [5:0]  alu_fn;
  logic        en8;
  logic        en32;
  logic [31:0] rd1;
  logic [31:0] rd2;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] m_hi8, m_lo8, m_hi32, m_lo32;

  always #5 clk = ~clk;

  alu_control_mdu_if #(.DATA_WIDTH(8))  bus8 ();
  alu_control_mdu_if #(.DATA_WIDTH(32)) bus32 ();

  assign bus8.ALUOp        = alu_op;
  assign bus8.ALUFunction  = alu_fn;
  assign bus8.Enable       = en8;
  assign bus8.ReadData1    = rd1[7:0];
  assign bus8.ReadData2    = rd2[7:0];
  assign bus32.ALUOp       = alu_op;
  assign bus32.ALUFunction = alu_fn;
  assign bus32.Enable      = en32;
  assign bus32.ReadData1   = rd1;
  assign bus32.ReadData2   = rd2;

  alu_control_mdu #(.DATA_WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(bus8));
  alu_control_mdu #(.DATA_WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(bus32));

  // Decode reference tables.
  logic [5:0] r_fn [11] = '{6'h24, 6'h25, 6'h27, 6'h20, 6'h22, 6'h02, 6'h00, 6'h10, 6'h12, 6'h19, 6'h1B};
  logic [3:0] r_cd [11] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd7, 4'd10, 4'd11, 4'd15, 4'd15};
  logic [5:0] i_op [6]  = '{6'h08, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04};
  logic [3:0] i_cd [6]  = '{4'd3, 4'd1, 4'd5, 4'd8, 4'd9, 4'd4};

  function automatic logic [3:0] ref_code(input logic [5:0] op, input logic [5:0] fn);
    logic [3:0] c;
    c = 4'b1001;
    if (op == 6'h00) begin
      for (int i = 0; i < 11; i++) if (r_fn[i] == fn) c = r_cd[i];
    end else begin
      for (int i = 0; i < 6; i++) if (i_op[i] == op) c = i_cd[i];
    end
    return c;
  endfunction

  function automatic bit ref_mdu(input logic [5:0] op, input logic [5:0] fn);
    return (op == 6'h00) && (fn == 6'h19 || fn == 6'h1B);
  endfunction

  function automatic logic sel_stall(input bit w32);
    return w32 ? bus32.Stall : bus8.Stall;
  endfunction
  function automatic logic sel_busy(input bit w32);
    return w32 ? bus32.Busy : bus8.Busy;
  endfunction
  function automatic logic [31:0] sel_hi(input bit w32);
    return w32 ? bus32.HI : {24'b0, bus8.HI};
  endfunction
  function automatic logic [31:0] sel_lo(input bit w32);
    return w32 ? bus32.LO : {24'b0, bus8.LO};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_hilo(input string tag);
    chk({tag, "_hi8"},  64'({24'b0, bus8.HI}), 64'(m_hi8));
    chk({tag, "_lo8"},  64'({24'b0, bus8.LO}), 64'(m_lo8));
    chk({tag, "_hi32"}, 64'(bus32.HI), 64'(m_hi32));
    chk({tag, "_lo32"}, 64'(bus32.LO), 64'(m_lo32));
  endtask

  // One non-MDU instruction for one cycle on both instances.
  task automatic plain_op(input logic [5:0] op, input logic [5:0] fn);
    alu_op = op; alu_fn = fn; en8 = 1'b1; en32 = 1'b1;
    @(negedge clk);
    chk("code8",   64'(bus8.ALUOperation),  64'(ref_code(op, fn)));
    chk("code32",  64'(bus32.ALUOperation), 64'(ref_code(op, fn)));
    chk("stall8",  64'(bus8.Stall),  64'(0));
    chk("stall32", 64'(bus32.Stall), 64'(0));
    check_hilo("hold");
    @(posedge clk); #1;
  endtask

  // Issue a MULTU/DIVU on one instance and follow it through DONE.
  task automatic mdu_op(input bit w32, input bit div, input logic [31:0] a, input logic [31:0] b);
    int w;
    int nst;
    int nbs;
    bit early;
    logic [31:0] ea, eb, eh, el, oh, ol;
    logic [63:0] prod;
    w = w32 ? 32 : 8;
    nst = 0; nbs = 0; early = 1'b0;
    ea = w32 ? a : {24'b0, a[7:0]};
    eb = w32 ? b : {24'b0, b[7:0]};
    if (div) begin
      if (eb == 0) begin
        el = w32 ? 32'hFFFF_FFFF : 32'h0000_00FF;
        eh = ea;
      end else begin
        el = ea / eb;
        eh = ea % eb;
      end
    end else begin
      prod = {32'b0, ea} * {32'b0, eb};
      eh = w32 ? prod[63:32] : {24'b0, prod[15:8]};
      el = w32 ? prod[31:0]  : {24'b0, prod[7:0]};
    end
    oh = w32 ? m_hi32 : m_hi8;
    ol = w32 ? m_lo32 : m_lo8;
    alu_op = 6'h00; alu_fn = div ? 6'h1B : 6'h19;
    rd1 = a; rd2 = b; en8 = !w32; en32 = w32;
    for (int k = 0; k <= w + 1; k++) begin
      @(negedge clk);
      if (k == 0) begin
        chk("issue_stall", 64'(sel_stall(w32)), 64'(1));
        chk("issue_busy",  64'(sel_busy(w32)),  64'(0));
        chk("issue_code",  64'(w32 ? bus32.ALUOperation : bus8.ALUOperation), 64'(4'b1111));
      end
      if (sel_stall(w32)) nst++;
      if (sel_busy(w32))  nbs++;
      if (k <= w && (sel_hi(w32) !== oh || sel_lo(w32) !== ol)) early = 1'b1;
      if (k == w + 1) begin
        chk("done_stall", 64'(sel_stall(w32)), 64'(0));
        chk("done_busy",  64'(sel_busy(w32)),  64'(1));
        chk(div ? "divu_hi" : "multu_hi", 64'(sel_hi(w32)), 64'(eh));
        chk(div ? "divu_lo" : "multu_lo", 64'(sel_lo(w32)), 64'(el));
      end
      @(posedge clk); #1;
      if (k == 0) begin
        rd1 = $urandom;
        rd2 = $urandom;
      end
    end
    chk("stall_cycles", 64'(nst), 64'(w + 1));
    chk("busy_cycles",  64'(nbs), 64'(w + 1));
    chk("hilo_early",   64'(early), 64'(0));
    if (w32) begin m_hi32 = eh; m_lo32 = el; end
    else     begin m_hi8  = eh; m_lo8  = el; end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] op, fn;
    bit w32, div;
    logic [31:0] a, b;
    m_hi8 = 0; m_lo8 = 0; m_hi32 = 0; m_lo32 = 0;
    reset = 1'b0; alu_op = 6'h20; alu_fn = 6'h00; en8 = 1'b0; en32 = 1'b0; rd1 = 0; rd2 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy8",   64'(bus8.Busy),   64'(0));
    chk("rst_stall8",  64'(bus8.Stall),  64'(0));
    chk("rst_busy32",  64'(bus32.Busy),  64'(0));
    chk("rst_stall32", 64'(bus32.Stall), 64'(0));
    check_hilo("rst");
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Decode sweep over every table row, plus default and wildcard cases.
    for (int i = 0; i < 11; i++) begin
      if (ref_mdu(6'h00, r_fn[i])) begin
        alu_op = 6'h00; alu_fn = r_fn[i]; en8 = 1'b0; en32 = 1'b0;
        @(negedge clk);
        chk("mdu_code", 64'(bus8.ALUOperation), 64'(4'b1111));
        chk("mdu_noen_stall", 64'(bus8.Stall), 64'(0));
        @(posedge clk); #1;
      end else begin
        plain_op(6'h00, r_fn[i]);
      end
    end
    for (int i = 0; i < 6; i++) plain_op(i_op[i], 6'($urandom));
    plain_op(6'h00, 6'h3F);
    plain_op(6'h08, 6'($urandom));

    // 32-bit MULTU of all ones, then MFHI reading a stable HI.
    mdu_op(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("max_hi", 64'(m_hi32), 64'(32'hFFFF_FFFE));
    for (int i = 0; i < 3; i++) begin
      plain_op(6'h00, 6'h10);
      chk("mfhi_code", 64'(bus32.ALUOperation), 64'(4'b1010));
    end

    // 8-bit directed divides, divide-by-zero, back-to-back.
    mdu_op(1'b0, 1'b1, 32'd200, 32'd7);
    plain_op(6'h00, 6'h12);
    mdu_op(1'b0, 1'b1, 32'h5A, 32'h0);
    plain_op(6'h00, 6'h24);
    mdu_op(1'b0, 1'b0, 32'd16, 32'd16);
    mdu_op(1'b0, 1'b1, 32'd255, 32'd16);

    // MULTU without Enable: no stall, no result change.
    alu_op = 6'h00; alu_fn = 6'h19; en8 = 1'b0; en32 = 1'b0; rd1 = 9; rd2 = 9;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("noen_stall", 64'(bus8.Stall), 64'(0));
      chk("noen_busy",  64'(bus8.Busy),  64'(0));
      check_hilo("noen");
      @(posedge clk); #1;
    end

    // Reset in the middle of a MULTU 3x5.
    alu_op = 6'h00; alu_fn = 6'h19; rd1 = 3; rd2 = 5; en8 = 1'b1;
    repeat (4) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    m_hi8 = 0; m_lo8 = 0; m_hi32 = 0; m_lo32 = 0;
    chk("midrst_stall", 64'(bus8.Stall), 64'(0));
    chk("midrst_busy",  64'(bus8.Busy),  64'(0));
    check_hilo("midrst");
    @(posedge clk); #1;
    en8 = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    mdu_op(1'b0, 1'b0, 32'd3, 32'd5);
    plain_op(6'h00, 6'h20);

    // Random mix of MDU and plain instructions.
    for (int n = 0; n < 40; n++) begin
      w32 = ($urandom_range(0, 7) == 0);
      div = 1'($urandom_range(0, 1));
      a   = $urandom;
      b   = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
      if (!w32 && $urandom_range(0, 3) == 0) b = {$urandom_range(0, 15)};
      mdu_op(w32, div, a, b);
      do begin
        op = ($urandom_range(0, 2) == 0) ? 6'h00 : 6'($urandom);
        fn = 6'($urandom);
      end while (ref_mdu(op, fn));
      plain_op(op, fn);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_control_mdu.md
# alu_control_mdu

Next-generation ALU control unit for the MIPS datapath. It decodes `{ALUOp, ALUFunction}` into the 4-bit ALU operation code, as the single-cycle decoder does. It also adds unsigned MULTU/DIVU support through an iterative multiply/divide sequencer with HI/LO registers. The block sits between the control unit, the register file and the ALU. While a multi-cycle operation runs, it drives `Stall` to freeze the PC and pipeline.

## Interface
- `DATA_WIDTH`, 32: operand, HI and LO width; must be ≥4.
- `CNT_WIDTH`, $clog2(DATA_WIDTH)+1: iteration counter width; derived, not overridden.
- `clk` input 1: system clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `ALUOp` input 6: opcode field from the control unit.
- `ALUFunction` input 6: function field of the instruction.
- `Enable` input 1: instruction in decode is valid; MULTU/DIVU only issue when high.
- `ReadData1` input DATA_WIDTH: rs operand (dividend / multiplicand).
- `ReadData2` input DATA_WIDTH: rt operand (divisor / multiplier).
- `ALUOperation` output 4: combinational ALU operation code.
- `Stall` output 1: hold PC and instruction.
- `Busy` output 1: sequencer not in IDLE.
- `HI` output DATA_WIDTH: HI register.
- `LO` output DATA_WIDTH: LO register.

## Operation
- Decode is combinational, using the casex order below. `x` means don't-care funct.
  - R-type (ALUOp 00): AND 24→0000, OR 25→0001, NOR 27→0010, ADD 20→0011, SUB 22→0100, SRL 02→0110, SLL 00→0111.
  - I-type: ADDI 08→0011, ORI 0D→0001, LUI 0F→0101, LW 23→1000, SW 2B→1001, BEQ 04→0100.
  - New: MFHI 00/10→1010, MFLO 00/12→1011, MULTU 00/19→1111, DIVU 00/1B→1111.
  - Default→1001.
- The datapath selects HI/LO for codes 1010/1011. Code 1111 means the ALU result is unused.
- FSM states: IDLE, BUSY, DONE.
  - IDLE→BUSY when `Enable` is high and decode is MULTU or DIVU. On this transition, capture the operands and the op type, and load the counter with DATA_WIDTH.
  - BUSY: one iteration per cycle; the counter decrements. When the counter is 1, the final iteration writes HI/LO and the FSM goes to DONE.
  - DONE→IDLE unconditionally. No issue is possible from DONE, so the still-present MULTU/DIVU instruction is not re-executed.
- MULTU: radix-2 shift-add on a 2·DATA_WIDTH accumulator. HI = upper half, LO = lower half; the full unsigned product is exact.
- DIVU: radix-2 restoring division. LO = quotient, HI = remainder.
- Divide-by-zero: LO = all ones, HI = dividend. The operation takes the same latency.
- HI/LO change only at the end of the final BUSY cycle. They are otherwise held, including across all other instructions.
- MFHI/MFLO cannot overlap an operation, because `Stall` freezes the instruction. They always read the completed result.

## Timing
- Reset (reset=0, asynchronous): FSM goes to IDLE, the counter and internal registers clear, HI=0, LO=0, Busy=0, Stall=0.
  - Reset mid-operation aborts the operation; HI/LO read 0 afterwards.
- `ALUOperation`: zero latency; a pure function of the current ALUOp/ALUFunction.
- `Stall` = (IDLE & Enable & decode∈{MULTU,DIVU}) | BUSY.
  - It is combinational in the issue cycle and low in DONE.
- `Busy` is registered: high in BUSY and DONE.
- Issue at cycle c0. BUSY covers c1..c(DATA_WIDTH). HI/LO are valid from c(DATA_WIDTH+1), which is the DONE cycle.
  - Stall is high for DATA_WIDTH+1 cycles.
  - The instruction occupies DATA_WIDTH+2 cycles in total.
- `Enable` low in the issue cycle means no issue and Stall=0.
- Operand changes after c0 are ignored.
- Back-to-back MULTU/DIVU: the second one issues in the cycle after DONE.

## Test plan
- Decode sweep: every listed {ALUOp, funct} pair → its code; ALUOp 00 with funct 3F → 1001; ALUOp 08 with any funct → 0011; Stall=0 for all non-MDU ops.
- DATA_WIDTH=32, MULTU 0xFFFFFFFF×0xFFFFFFFF → Stall high for 33 cycles; in DONE, HI=0xFFFFFFFE and LO=0x00000001; then MFHI → code 1010 with HI stable.
- DATA_WIDTH=8, DIVU 200/7 → in the DONE cycle (c9), LO=0x1C and HI=0x04; Busy high c1..c9.
- DATA_WIDTH=8, DIVU 0x5A/0 → LO=0xFF, HI=0x5A; same latency as normal division.
- Reset pulse (reset=0) at c4 of a MULTU 3×5 → immediate IDLE with HI=LO=0, Stall=0; after release, re-issued MULTU gives LO=15, HI=0.
- DATA_WIDTH=8, back-to-back MULTU 16×16 then DIVU 255/16 → first gives HI=0x01, LO=0x00; second issues one cycle after DONE and gives LO=0x0F, HI=0x0F. With Enable=0, a MULTU produces no stall and HI/LO are unchanged.
